// File: rtl/ysyx_041514_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_041514_div_ctrl_pkg
// Shared definitions for the RV64M divide/remainder sequencing stage:
//   - datapath width
//   - funct encodings of the four divide ops (op[1] = remainder, op[0] = unsigned)
//   - controller state encoding
//   - sign-extension helpers for the *W variants
// ---------------------------------------------------------------------------
package ysyx_041514_div_ctrl_pkg;

  localparam int ysyx_041514_XLEN = 64;

  localparam logic [1:0] ysyx_041514_DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] ysyx_041514_DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] ysyx_041514_DIV_OP_REM  = 2'b10;
  localparam logic [1:0] ysyx_041514_DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } div_state_e;

  // Sign-extend the low word to the full datapath width.
  function automatic logic [ysyx_041514_XLEN-1:0] sext32(input logic [ysyx_041514_XLEN-1:0] v);
    return {{(ysyx_041514_XLEN-32){v[31]}}, v[31:0]};
  endfunction

  // Final rd value: *W results are always sign-extended from bit 31.
  function automatic logic [ysyx_041514_XLEN-1:0] fit_width(input logic w,
                                                            input logic [ysyx_041514_XLEN-1:0] v);
    logic [ysyx_041514_XLEN-1:0] r;
    if (w) begin
      r = sext32(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/ysyx_041514_div_special.sv
// ---------------------------------------------------------------------------
// ysyx_041514_div_special
// Combinational detector for the RISC-V divide special cases that must not
// reach the divider: divide-by-zero and signed overflow (most-negative / -1).
// Ports:
//   op             in  2     divide op encoding
//   w              in  1     32-bit (*W) variant; cases evaluated on [31:0]
//   rs1, rs2       in  XLEN  dividend, divisor
//   is_special     out 1     operands hit a special case
//   special_result out XLEN  architectural result, already width-adjusted
// ---------------------------------------------------------------------------
module ysyx_041514_div_special
  import ysyx_041514_div_ctrl_pkg::*;
#(
  parameter int XLEN = ysyx_041514_XLEN
) (
  input  logic [1:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            is_special,
  output logic [XLEN-1:0] special_result
);

  logic            is_signed_s;
  logic            is_rem_s;
  logic            div_zero_s;
  logic            overflow_s;
  logic [XLEN-1:0] raw_s;

  // Classify operands on the effective width and pick the architectural result.
  always_comb begin
    is_signed_s = ~op[0];
    is_rem_s    = op[1];
    div_zero_s  = 1'b0;
    overflow_s  = 1'b0;
    raw_s       = {XLEN{1'b0}};

    if (w) begin
      div_zero_s = (rs2[31:0] == 32'h0000_0000);
      overflow_s = is_signed_s && (rs1[31:0] == 32'h8000_0000) && (rs2[31:0] == 32'hFFFF_FFFF);
    end else begin
      div_zero_s = (rs2 == {XLEN{1'b0}});
      overflow_s = is_signed_s && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
    end

    // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
    if (div_zero_s) begin
      if (is_rem_s) begin
        raw_s = rs1;
      end else begin
        raw_s = {XLEN{1'b1}};
      end
    end else if (overflow_s) begin
      if (is_rem_s) begin
        raw_s = {XLEN{1'b0}};
      end else begin
        raw_s = rs1;
      end
    end else begin
      raw_s = {XLEN{1'b0}};
    end

    is_special     = div_zero_s | overflow_s;
    special_result = fit_width(w, raw_s);
  end

endmodule

// File: rtl/ysyx_041514_div_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_041514_div_ctrl
// Sequences one RV64M divide/remainder op between EX issue and the 64-bit
// divider. Operands are latched on accept and held while the divider runs;
// special cases complete without the divider. A flush while the divider is
// running parks the controller in DRAIN until the divider answers, so the
// divider always sees a complete request/response pair.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   in_valid_i / in_ready_o     issue handshake (op_i, w_i, rs1_i, rs2_i)
//   flush_i                     kill the in-flight op
//   div_valid_o, div_signed_o,
//   div32_o, dividend_o,
//   divisor_o                   divider request
//   div_ready_i, div_quot_i,
//   div_rem_i                   divider response
//   out_valid_o / out_ready_i   writeback handshake, out_data_o = rd value
//   busy_o                      EX stall (state != IDLE)
// ---------------------------------------------------------------------------
module ysyx_041514_div_ctrl
  import ysyx_041514_div_ctrl_pkg::*;
#(
  parameter int XLEN = ysyx_041514_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      op_i,
  input  logic            w_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            div_valid_o,
  output logic            div_signed_o,
  output logic            div32_o,
  output logic [XLEN-1:0] dividend_o,
  output logic [XLEN-1:0] divisor_o,
  input  logic            div_ready_i,
  input  logic [XLEN-1:0] div_quot_i,
  input  logic [XLEN-1:0] div_rem_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_data_o,
  output logic            busy_o
);

  div_state_e      state_r;
  div_state_e      next_state_s;
  logic            rem_r;
  logic            signed_r;
  logic            w_r;
  logic [XLEN-1:0] rs1_r;
  logic [XLEN-1:0] rs2_r;
  logic [XLEN-1:0] result_r;

  logic            accept_s;
  logic            is_special_s;
  logic [XLEN-1:0] special_result_s;
  logic [XLEN-1:0] div_sel_s;

  // Special cases are judged on the incoming operands so they resolve in the accept cycle.
  ysyx_041514_div_special #(
    .XLEN(XLEN)
  ) u_special (
    .op             (op_i),
    .w              (w_i),
    .rs1            (rs1_i),
    .rs2            (rs2_i),
    .is_special     (is_special_s),
    .special_result (special_result_s)
  );

  // Flush has priority over a new request in IDLE.
  assign in_ready_o   = (state_r == ST_IDLE) & ~flush_i;
  assign accept_s     = in_valid_i & in_ready_o;

  assign div_valid_o  = (state_r == ST_BUSY) | (state_r == ST_DRAIN);
  assign out_valid_o  = (state_r == ST_DONE);
  assign busy_o       = (state_r != ST_IDLE);
  assign div_signed_o = signed_r;
  assign div32_o      = w_r;
  assign dividend_o   = rs1_r;
  assign divisor_o    = rs2_r;
  assign out_data_o   = result_r;

  // Pick quotient or remainder from the divider and fix up the *W width.
  always_comb begin
    div_sel_s = {XLEN{1'b0}};
    if (rem_r) begin
      div_sel_s = fit_width(w_r, div_rem_i);
    end else begin
      div_sel_s = fit_width(w_r, div_quot_i);
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; div_ready_i only matters while a request is outstanding.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_special_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_BUSY;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (div_ready_i) begin
          if (flush_i) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_DONE;
          end
        end else if (flush_i) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_DRAIN: begin
        if (div_ready_i) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (out_ready_i || flush_i) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Operand/op latch: loaded on accept, held stable for the divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_r    <= 1'b0;
      signed_r <= 1'b0;
      w_r      <= 1'b0;
      rs1_r    <= {XLEN{1'b0}};
      rs2_r    <= {XLEN{1'b0}};
    end else if (accept_s) begin
      rem_r    <= op_i[1];
      signed_r <= ~op_i[0];
      w_r      <= w_i;
      rs1_r    <= rs1_i;
      rs2_r    <= rs2_i;
    end else begin
      rem_r    <= rem_r;
      signed_r <= signed_r;
      w_r      <= w_r;
      rs1_r    <= rs1_r;
      rs2_r    <= rs2_r;
    end
  end

  // Result register: special result on accept, divider result on a clean completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r <= {XLEN{1'b0}};
    end else if (accept_s && is_special_s) begin
      result_r <= special_result_s;
    end else if ((state_r == ST_BUSY) && div_ready_i && !flush_i) begin
      result_r <= div_sel_s;
    end else begin
      result_r <= result_r;
    end
  end

endmodule
